rambus_block_reader: RTL and testbench
======================================

// Module: rambus_block_reader
// PURPOSE
//  Wishbone initiator for the shared OpenRAM rambus: the master end of port B of the dual-port
//  OpenRAM wrapper. On start, fetches a block of 32-bit words via classic single reads (one outstanding).
//  Buffers the words in a small FIFO and streams them out on a valid/ready interface.
//  Used by user projects as a sample/pattern player from RAM that caravel has preloaded.
// PARAMETERS
//  FIFO_DEPTH      4    output FIFO entries (power of 2, >=2)
//  TIMEOUT_CYCLES  64   max cycles with cyc high and no ack before abort (>=2)
// PORTS
//  wb_clk_i         in   1   clock; the only clock
//  wb_rst_i         in   1   reset, asynchronous, active-high
//  start            in   1   1-cycle pulse; latches base_addr/len_words/loop; ignored while busy
//  stop             in   1   1-cycle pulse; abort the block (see BEHAVIOUR)
//  base_addr        in   10  byte address of first word; bits [1:0] ignored (treated as 0)
//  len_words        in   9   words per block, 0..256
//  loop             in   1   1 = restart at base_addr after the last word, until stop
//  busy             out  1   high from the cycle after an accepted start until return to IDLE
//  done             out  1   1-cycle pulse when the last word of a non-loop block is acked
//  err              out  1   sticky timeout flag; cleared by the next accepted start
//  out_data         out  32  FIFO head word
//  out_valid        out  1   FIFO not empty
//  out_ready        in   1   consumer accepts out_data when out_valid & out_ready
//  rambus_wb_clk_o  out  1   = wb_clk_i
//  rambus_wb_rst_o  out  1   = wb_rst_i
//  rambus_wb_cyc_o/stb_o  out 1  cycle/strobe, always driven equal
//  rambus_wb_we_o   out  1   constant 0
//  rambus_wb_sel_o  out  4   constant 4'hF
//  rambus_wb_dat_o  out  32  constant 0
//  rambus_wb_adr_o  out  10  byte address of the current read
//  rambus_wb_ack_i  in   1   slave ack
//  rambus_wb_dat_i  in   32  read data, valid when ack is high
// BEHAVIOUR
//  Reset: all outputs 0 (cyc, stb, adr, busy, done, err, out_valid, out_data); FIFO empty; state IDLE.
//   Takes effect immediately, no clock edge needed, including mid-transfer.
//  FSM states: IDLE, REQ, GAP, FLUSH.
//   IDLE  : on start with len_words!=0 -> latch inputs, addr<=base & ~3, remain<=len, clear err, go GAP.
//           start with len_words==0 -> done pulses next cycle; busy stays 0; no bus activity.
//   GAP   : cyc/stb low. If (fifo_count < FIFO_DEPTH) go REQ; otherwise wait here (backpressure).
//   REQ   : cyc=stb=1 with adr held stable. On edge sampling ack=1:
//           push dat_i into FIFO, addr<=addr+4 (mod 1024, wraps 0x3FC->0x000), remain<=remain-1.
//           If remain was 1: loop=1 -> reload addr/remain from latched values, go GAP;
//           loop=0 -> done pulse next cycle, go IDLE.
//           Otherwise go GAP. cyc/stb are low for >=1 cycle between reads.
//           If TIMEOUT_CYCLES consecutive REQ cycles pass without ack: drop cyc/stb, err<=1, go IDLE
//           (no done pulse; FIFO contents kept).
//   stop  : in IDLE, no effect. In GAP -> FLUSH. In REQ -> wait for ack (data discarded) or timeout,
//           then FLUSH. FLUSH empties the FIFO in one cycle, then IDLE. No done pulse.
//  busy = (state != IDLE). The FIFO drains independently of the FSM, so out_valid may stay high in IDLE.
//  FIFO: a push on ack is visible on out_valid the next cycle. A simultaneous push and pop is legal.
//   Count never exceeds FIFO_DEPTH, because REQ is entered only with space available
//   and only one read is ever outstanding.
//  start coincident with stop: stop wins. Start during busy: ignored.
//  Ack while not in REQ: ignored.
// TESTING
//  1 base=0x010 len=4 loop=0 ready=1, slave acks 1 cycle after stb with data=adr
//    -> reads at 0x010,0x014,0x018,0x01C; out 0x10,0x14,0x18,0x1C in order; one done pulse; busy falls.
//  2 base=0x3F8 len=4 -> adr sequence 0x3F8,0x3FC,0x000,0x004 (wrap).
//  3 FIFO_DEPTH=4, len=8, ready=0 -> exactly 4 reads, then cyc stays low;
//    ready=1 -> remaining 4 reads; all 8 words in order, no loss or duplicate.
//  4 slave never acks, TIMEOUT_CYCLES=16 -> cyc drops after 16 REQ cycles; err=1; busy=0; no done.
//    Next start clears err.
//  5 loop=1 len=2 base=0x100 -> adr 0x100,0x104,0x100,0x104...; stop asserted mid-REQ
//    -> cyc held until ack, then FIFO empty, out_valid=0, busy=0, no done.
//  6 assert wb_rst_i asynchronously during REQ -> cyc/stb/busy/out_valid 0 before the next edge;
//    len=0 start after reset -> done pulse, no cyc.

Source files
------------

// File: rtl/rambus_block_reader_if.sv
// Wishbone bus between the block reader (master) and the OpenRAM port-B slave.
// Also carries the clock/reset forwarded to the RAM wrapper.
interface rambus_block_reader_if;
    logic        rambus_wb_clk_o;
    logic        rambus_wb_rst_o;
    logic        rambus_wb_cyc_o;
    logic        rambus_wb_stb_o;
    logic        rambus_wb_we_o;
    logic [3:0]  rambus_wb_sel_o;
    logic [31:0] rambus_wb_dat_o;
    logic [9:0]  rambus_wb_adr_o;
    logic        rambus_wb_ack_i;
    logic [31:0] rambus_wb_dat_i;

    modport master (
        output rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_cyc_o, rambus_wb_stb_o,
        output rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_adr_o,
        input  rambus_wb_ack_i, rambus_wb_dat_i
    );

    modport slave (
        input  rambus_wb_clk_o, rambus_wb_rst_o, rambus_wb_cyc_o, rambus_wb_stb_o,
        input  rambus_wb_we_o, rambus_wb_sel_o, rambus_wb_dat_o, rambus_wb_adr_o,
        output rambus_wb_ack_i, rambus_wb_dat_i
    );
endinterface

// File: rtl/rambus_block_reader.sv
// Wishbone block reader: fetches len_words words with single classic reads (one outstanding)
// into a small FIFO and streams them out on a valid/ready port; optional looping playback.
module rambus_block_reader #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  base_addr,
    input  logic [8:0]  len_words,
    input  logic        loop,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    rambus_block_reader_if.master rambus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GAP   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t         state_r;
    logic [9:0]     adr_r;
    logic [9:0]     base_r;
    logic [8:0]     len_r;
    logic [8:0]     remain_r;
    logic           loop_r;
    logic           stop_pend_r;
    logic           cyc_r;
    logic           busy_r;
    logic           done_r;
    logic           err_r;
    logic [TW-1:0]  tmo_r;

    logic [31:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;

    logic [AW:0]    count_s;
    logic           not_empty_s;
    logic           space_s;
    logic           push_s;
    logic           pop_s;
    logic           stopping_s;
    logic           ack_s;
    logic           unused_s;

    assign ack_s    = rambus.rambus_wb_ack_i;
    assign unused_s = ^base_addr[1:0];

    // FIFO status and handshake decode
    always_comb begin
        count_s     = wr_ptr_r - rd_ptr_r;
        not_empty_s = (count_s != {(AW+1){1'b0}});
        space_s     = (count_s < FIFO_FULL);
        pop_s       = not_empty_s & out_ready;
        stopping_s  = stop_pend_r | stop;
        // a read that completes after stop is discarded rather than buffered
        push_s      = (state_r == REQ) & ack_s & ~stopping_s;
    end

    // Output FIFO storage and pointers; FLUSH discards everything in one cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (state_r == FLUSH) begin
            rd_ptr_r <= wr_ptr_r;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= rambus.rambus_wb_dat_i;
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Read sequencer FSM with registered bus and status outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r     <= IDLE;
            adr_r       <= 10'd0;
            base_r      <= 10'd0;
            len_r       <= 9'd0;
            remain_r    <= 9'd0;
            loop_r      <= 1'b0;
            stop_pend_r <= 1'b0;
            cyc_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            tmo_r       <= {TW{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        err_r <= 1'b0;
                        if (len_words != 9'd0) begin
                            base_r      <= {base_addr[9:2], 2'b00};
                            adr_r       <= {base_addr[9:2], 2'b00};
                            len_r       <= len_words;
                            remain_r    <= len_words;
                            loop_r      <= loop;
                            stop_pend_r <= 1'b0;
                            busy_r      <= 1'b1;
                            state_r     <= GAP;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state_r <= FLUSH;
                    end else if (space_s) begin
                        cyc_r   <= 1'b1;
                        tmo_r   <= {TW{1'b0}};
                        state_r <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        cyc_r <= 1'b0;
                        if (stopping_s) begin
                            state_r <= FLUSH;
                        end else if (remain_r == 9'd1) begin
                            if (loop_r) begin
                                adr_r    <= base_r;
                                remain_r <= len_r;
                                state_r  <= GAP;
                            end else begin
                                adr_r    <= adr_r + 10'd4;
                                remain_r <= 9'd0;
                                done_r   <= 1'b1;
                                busy_r   <= 1'b0;
                                state_r  <= IDLE;
                            end
                        end else begin
                            adr_r    <= adr_r + 10'd4;
                            remain_r <= remain_r - 9'd1;
                            state_r  <= GAP;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        cyc_r <= 1'b0;
                        err_r <= 1'b1;
                        if (stopping_s) begin
                            state_r <= FLUSH;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                        if (stop) begin
                            stop_pend_r <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    busy_r      <= 1'b0;
                    stop_pend_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    cyc_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign out_valid = not_empty_s;
    assign out_data  = mem_r[rd_ptr_r[AW-1:0]];

    assign rambus.rambus_wb_clk_o = wb_clk_i;
    assign rambus.rambus_wb_rst_o = wb_rst_i;
    assign rambus.rambus_wb_cyc_o = cyc_r;
    assign rambus.rambus_wb_stb_o = cyc_r;
    assign rambus.rambus_wb_we_o  = 1'b0;
    assign rambus.rambus_wb_sel_o = 4'hF;
    assign rambus.rambus_wb_dat_o = 32'd0;
    assign rambus.rambus_wb_adr_o = adr_r;

endmodule

// File: tb/tb_rambus_block_reader.sv
// Directed bench for rambus_block_reader: a registered-ack Wishbone slave returning data = adr,
// negedge monitors for bus reads / stream words / done pulses, and hand-computed expectations.
module tb_rambus_block_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [9:0]  base_addr = 10'd0;
    logic [8:0]  len_words = 9'd0;
    logic        loop = 1'b0;
    logic        busy, done, err, out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic        ack_en = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0]  adr_q [$];
    logic [31:0] out_q [$];
    int          done_cnt = 0;
    int          cyc_cycles = 0;

    rambus_block_reader_if rb ();

    rambus_block_reader #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .len_words (len_words),
        .loop      (loop),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rambus    (rb)
    );

    always #5 clk = ~clk;

    // slave: ack one cycle after stb, data = address
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rb.rambus_wb_ack_i <= 1'b0;
            rb.rambus_wb_dat_i <= 32'd0;
        end else begin
            rb.rambus_wb_ack_i <= rb.rambus_wb_cyc_o & rb.rambus_wb_stb_o & ~rb.rambus_wb_ack_i & ack_en;
            rb.rambus_wb_dat_i <= {22'd0, rb.rambus_wb_adr_o};
        end
    end

    always @(negedge clk) begin
        if (rb.rambus_wb_cyc_o && rb.rambus_wb_stb_o && rb.rambus_wb_ack_i) adr_q.push_back(rb.rambus_wb_adr_o);
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (done) done_cnt++;
        if (rb.rambus_wb_cyc_o) cyc_cycles++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] b, input logic [8:0] l, input logic lp);
        @(posedge clk); #1;
        base_addr = b; len_words = l; loop = lp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check_val(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int a0, o0, d0, c0, n;
        logic [9:0] exp_adr [4];

        // reset state
        #12;
        check_val("rst_cyc", {31'd0, rb.rambus_wb_cyc_o}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_data", out_data, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_adr", {22'd0, rb.rambus_wb_adr_o}, 32'd0);
        check_val("rst_o", {31'd0, rb.rambus_wb_rst_o}, 32'd1);
        check_val("const_bus", {rb.rambus_wb_we_o, rb.rambus_wb_sel_o, 27'd0}, {1'b0, 4'hF, 27'd0});
        @(posedge clk); #1; rst = 1'b0;

        // 1: basic block of 4
        a0 = adr_q.size(); o0 = out_q.size(); d0 = done_cnt;
        do_start(10'h010, 9'd4, 1'b0);
        check_val("t1_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle("t1_idle", 200);
        repeat (4) @(negedge clk);
        check_val("t1_nreads", adr_q.size() - a0, 32'd4);
        check_val("t1_nwords", out_q.size() - o0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (adr_q.size() > a0 + i) check_val("t1_adr", {22'd0, adr_q[a0+i]}, 32'h10 + 32'(4*i));
            if (out_q.size() > o0 + i) check_val("t1_out", out_q[o0+i], 32'h10 + 32'(4*i));
        end
        check_val("t1_done", done_cnt - d0, 32'd1);

        // 2: address wrap
        a0 = adr_q.size();
        exp_adr[0] = 10'h3F8; exp_adr[1] = 10'h3FC; exp_adr[2] = 10'h000; exp_adr[3] = 10'h004;
        do_start(10'h3F8, 9'd4, 1'b0);
        wait_idle("t2_idle", 200);
        repeat (4) @(negedge clk);
        check_val("t2_nreads", adr_q.size() - a0, 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (adr_q.size() > a0 + i) check_val("t2_adr", {22'd0, adr_q[a0+i]}, {22'd0, exp_adr[i]});
        end

        // 3: backpressure with a full FIFO
        a0 = adr_q.size(); o0 = out_q.size();
        out_ready = 1'b0;
        do_start(10'h040, 9'd8, 1'b0);
        repeat (60) @(negedge clk);
        check_val("t3_reads_full", adr_q.size() - a0, 32'd4);
        check_val("t3_cyc_low", {31'd0, rb.rambus_wb_cyc_o}, 32'd0);
        check_val("t3_valid", {31'd0, out_valid}, 32'd1);
        check_val("t3_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle("t3_idle", 300);
        repeat (6) @(negedge clk);
        check_val("t3_nreads", adr_q.size() - a0, 32'd8);
        check_val("t3_nwords", out_q.size() - o0, 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (out_q.size() > o0 + i) check_val("t3_out", out_q[o0+i], 32'h40 + 32'(4*i));
        end

        // 4: slave never acks -> timeout
        d0 = done_cnt; c0 = cyc_cycles;
        ack_en = 1'b0;
        do_start(10'h020, 9'd2, 1'b0);
        wait_idle("t4_idle", 100);
        repeat (3) @(negedge clk);
        check_val("t4_cyc_cycles", cyc_cycles - c0, 32'd16);
        check_val("t4_err", {31'd0, err}, 32'd1);
        check_val("t4_busy", {31'd0, busy}, 32'd0);
        check_val("t4_no_done", done_cnt - d0, 32'd0);
        ack_en = 1'b1;
        do_start(10'h000, 9'd1, 1'b0);
        check_val("t4_err_clr", {31'd0, err}, 32'd0);
        wait_idle("t4b_idle", 100);
        repeat (3) @(negedge clk);

        // 5: loop, then stop in the middle of a read
        a0 = adr_q.size(); d0 = done_cnt;
        do_start(10'h100, 9'd2, 1'b1);
        n = 0;
        while (adr_q.size() - a0 < 4 && n < 300) begin @(negedge clk); n++; end
        check_val("t5_loop_reads", {31'd0, (adr_q.size() - a0 >= 4)}, 32'd1);
        n = 0;
        while (!(rb.rambus_wb_cyc_o && !rb.rambus_wb_ack_i) && n < 50) begin @(negedge clk); n++; end
        check_val("t5_found_req", {31'd0, rb.rambus_wb_cyc_o}, 32'd1);
        stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        @(negedge clk);
        check_val("t5_cyc_held", {31'd0, rb.rambus_wb_cyc_o}, 32'd1);
        wait_idle("t5_idle", 50);
        check_val("t5_valid", {31'd0, out_valid}, 32'd0);
        check_val("t5_no_done", done_cnt - d0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (adr_q.size() > a0 + i) check_val("t5_adr", {22'd0, adr_q[a0+i]}, (i % 2 == 0) ? 32'h100 : 32'h104);
        end

        // 6: asynchronous reset during REQ, then zero-length start
        ack_en = 1'b0; out_ready = 1'b0;
        do_start(10'h080, 9'd4, 1'b0);
        n = 0;
        while (!rb.rambus_wb_cyc_o && n < 20) begin @(negedge clk); n++; end
        check_val("t6_in_req", {31'd0, rb.rambus_wb_cyc_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_cyc", {31'd0, rb.rambus_wb_cyc_o}, 32'd0);
        check_val("t6_stb", {31'd0, rb.rambus_wb_stb_o}, 32'd0);
        check_val("t6_busy", {31'd0, busy}, 32'd0);
        check_val("t6_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1; rst = 1'b0; ack_en = 1'b1; out_ready = 1'b1;
        d0 = done_cnt; c0 = cyc_cycles;
        do_start(10'h000, 9'd0, 1'b0);
        check_val("t6_done", {31'd0, done}, 32'd1);
        check_val("t6_busy0", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check_val("t6_done_pulse", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);
        check_val("t6_done_cnt", done_cnt - d0, 32'd1);
        check_val("t6_no_cyc", cyc_cycles - c0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
